// File: rtl/vector_pkg.sv
// Shared definitions for the vector collector and serializer stages.
package vector_pkg;

  localparam int unsigned FP_W = 32;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_index_counter.sv
// Wrap-around index counter: counts 0..N-1 on enable, synchronous clear wins.
module vector_index_counter
  import vector_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  output logic [idx_w(N)-1:0]   count,
  output logic                  wrap
);

  localparam int unsigned W = idx_w(N);

  assign wrap = enable && (count == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vector_collector.sv
// Collects VLEN serial 32-bit words into a double-buffered parallel vector.
module vector_collector
  import vector_pkg::*;
#(
  parameter int unsigned VLEN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                in_num,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clear,
  output logic [32*VLEN-1:0]         out_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [idx_w(VLEN)-1:0]     fill_idx
);

  localparam int unsigned IDX_W = idx_w(VLEN);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                   state;
  logic [FP_W*VLEN-1:0]     fill_buf;
  logic [FP_W*VLEN-1:0]     next_buf;
  logic                     accept;
  logic                     last;
  logic                     slot_free;
  logic                     load_direct;
  logic                     load_held;

  assign in_ready    = (state == FILL);
  assign accept      = in_valid && in_ready && !clear;
  assign slot_free   = !out_valid || out_ready;
  assign load_direct = accept && last && slot_free;
  assign load_held   = (state == HOLD) && out_ready && !clear;

  vector_index_counter #(.N(VLEN)) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (accept),
    .clear  (clear),
    .count  (fill_idx),
    .wrap   (last)
  );

  // Fill buffer with the incoming word merged in, so a completing vector
  // can be forwarded to out_vec in the same cycle it is accepted.
  always_comb begin
    next_buf = fill_buf;
    for (int unsigned k = 0; k < VLEN; k++) begin
      if (fill_idx == IDX_W'(k)) next_buf[k*FP_W +: FP_W] = in_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf <= '0;
    end else if (accept) begin
      fill_buf <= next_buf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      out_vec   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_direct) begin
        out_vec   <= next_buf;
        out_valid <= 1'b1;
      end else if (load_held) begin
        out_vec   <= fill_buf;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        state <= FILL;
      end else begin
        case (state)
          FILL:    if (accept && last && !slot_free) state <= HOLD;
          HOLD:    if (out_ready) state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_collector.sv
// Directed self-checking bench for vector_collector with VLEN=4 and VLEN=1.
module tb_vector_collector;

  logic          clk;
  logic          rst_n;

  logic [31:0]   in_num4;
  logic          in_valid4;
  logic          in_ready4;
  logic          clear4;
  logic [127:0]  out_vec4;
  logic          out_valid4;
  logic          out_ready4;
  logic [1:0]    fill_idx4;

  logic [31:0]   in_num1;
  logic          in_valid1;
  logic          in_ready1;
  logic          clear1;
  logic [31:0]   out_vec1;
  logic          out_valid1;
  logic          out_ready1;
  logic [0:0]    fill_idx1;

  int n_assert;
  int n_fail;

  vector_collector #(.VLEN(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_num    (in_num4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .clear     (clear4),
    .out_vec   (out_vec4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .fill_idx  (fill_idx4)
  );

  vector_collector #(.VLEN(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_num    (in_num1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .clear     (clear1),
    .out_vec   (out_vec1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .fill_idx  (fill_idx1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] w);
    in_num4   = w;
    in_valid4 = 1'b1;
    step();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    in_num4 = '0; in_valid4 = 1'b0; clear4 = 1'b0; out_ready4 = 1'b0;
    in_num1 = '0; in_valid1 = 1'b0; clear1 = 1'b0; out_ready1 = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid4), 128'(1'b0));
    chk("rst_out_vec",   out_vec4, '0);
    chk("rst_fill_idx",  128'(fill_idx4), 128'(0));
    chk("rst_in_ready",  128'(in_ready4), 128'(1'b1));
    chk("rst_in_ready1", 128'(in_ready1), 128'(1'b1));
    #13 rst_n = 1'b1;
    step();

    // Basic vector with out_ready held high
    out_ready4 = 1'b1;
    push4(32'h3F800000);
    push4(32'h40000000);
    push4(32'h40400000);
    chk("t1_fill_idx3",  128'(fill_idx4), 128'(3));
    chk("t1_not_valid",  128'(out_valid4), 128'(1'b0));
    push4(32'h40800000);
    chk("t1_valid",      128'(out_valid4), 128'(1'b1));
    chk("t1_vec",        out_vec4, 128'h40800000_40400000_40000000_3F800000);
    chk("t1_idx_wrap",   128'(fill_idx4), 128'(0));
    in_valid4 = 1'b0;
    step();
    chk("t1_consumed",   128'(out_valid4), 128'(1'b0));
    chk("t1_vec_hold",   out_vec4, 128'h40800000_40400000_40000000_3F800000);

    // Back-pressure: second vector waits in the fill buffer
    out_ready4 = 1'b0;
    push4(32'hA0000000); push4(32'hA0000001); push4(32'hA0000002); push4(32'hA0000003);
    chk("t2_first_valid", 128'(out_valid4), 128'(1'b1));
    chk("t2_first_vec",   out_vec4, 128'hA0000003_A0000002_A0000001_A0000000);
    push4(32'hB0000000); push4(32'hB0000001); push4(32'hB0000002);
    chk("t2_ready_mid",   128'(in_ready4), 128'(1'b1));
    push4(32'hB0000003);
    chk("t2_pending",     128'(in_ready4), 128'(1'b0));
    chk("t2_stable",      out_vec4, 128'hA0000003_A0000002_A0000001_A0000000);
    push4(32'hDEADBEEF);
    chk("t2_still_pend",  128'(in_ready4), 128'(1'b0));
    chk("t2_stable2",     out_vec4, 128'hA0000003_A0000002_A0000001_A0000000);
    chk("t2_idx_held",    128'(fill_idx4), 128'(0));
    out_ready4 = 1'b1;
    step();
    chk("t2_second_vec",  out_vec4, 128'hB0000003_B0000002_B0000001_B0000000);
    chk("t2_second_valid",128'(out_valid4), 128'(1'b1));
    chk("t2_ready_back",  128'(in_ready4), 128'(1'b1));
    chk("t2_no_accept",   128'(fill_idx4), 128'(0));
    in_valid4 = 1'b0;
    step();
    chk("t2_drained",     128'(out_valid4), 128'(1'b0));

    // Clear drops the partial vector and the word offered alongside it
    push4(32'hC0000000); push4(32'hC0000001);
    chk("t3_idx2",        128'(fill_idx4), 128'(2));
    clear4  = 1'b1;
    in_num4 = 32'hDEAD0000;
    step();
    clear4 = 1'b0;
    chk("t3_idx_clr",     128'(fill_idx4), 128'(0));
    chk("t3_no_valid",    128'(out_valid4), 128'(1'b0));
    push4(32'hD0000000); push4(32'hD0000001); push4(32'hD0000002); push4(32'hD0000003);
    chk("t3_vec",         out_vec4, 128'hD0000003_D0000002_D0000001_D0000000);
    chk("t3_valid",       128'(out_valid4), 128'(1'b1));

    // Clear leaves a held output untouched
    out_ready4 = 1'b0;
    push4(32'hE0000000); push4(32'hE0000001);
    in_valid4 = 1'b0;
    clear4 = 1'b1;
    step();
    clear4 = 1'b0;
    chk("t3_clr_keep_v",  128'(out_valid4), 128'(1'b1));
    chk("t3_clr_keep_vec",out_vec4, 128'hD0000003_D0000002_D0000001_D0000000);
    chk("t3_clr_idx",     128'(fill_idx4), 128'(0));

    // Asynchronous reset in the middle of a vector
    push4(32'hE1000000); push4(32'hE1000001);
    in_valid4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid",   128'(out_valid4), 128'(1'b0));
    chk("t4_rst_vec",     out_vec4, '0);
    chk("t4_rst_idx",     128'(fill_idx4), 128'(0));
    chk("t4_rst_ready",   128'(in_ready4), 128'(1'b1));
    #1 rst_n = 1'b1;
    out_ready4 = 1'b1;
    push4(32'hF0000000); push4(32'hF0000001); push4(32'hF0000002); push4(32'hF0000003);
    in_valid4 = 1'b0;
    chk("t4_slot0",       128'(out_vec4[31:0]), 128'(32'hF0000000));
    chk("t4_vec",         out_vec4, 128'hF0000003_F0000002_F0000001_F0000000);

    // VLEN=1: every accept completes a vector
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    in_num1    = 32'hBF800000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("v1_valid", 128'(out_valid1), 128'(1'b1));
      chk("v1_ready", 128'(in_ready1), 128'(1'b1));
      chk("v1_vec",   128'(out_vec1), 128'(32'hBF800000));
      chk("v1_idx",   128'(fill_idx1), 128'(0));
    end
    in_num1 = 32'h12345678;
    step();
    chk("v1_update",      128'(out_vec1), 128'(32'h12345678));
    out_ready1 = 1'b0;
    in_num1 = 32'h0BADF00D;
    step();
    chk("v1_pending",     128'(in_ready1), 128'(1'b0));
    chk("v1_held",        128'(out_vec1), 128'(32'h12345678));
    out_ready1 = 1'b1;
    in_num1 = 32'h55555555;
    step();
    chk("v1_released",    128'(out_vec1), 128'(32'h0BADF00D));
    chk("v1_ready_back",  128'(in_ready1), 128'(1'b1));
    in_valid1 = 1'b0;
    step();
    chk("v1_drained",     128'(out_valid1), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
